// File: rtl/stratego_turn_fsm_pkg.sv
// Shared cell codes, move-command encodings and FSM state encodings for the
// Stratego turn controller.
package stratego_turn_fsm_pkg;

  // Rank field codes (low five bits of a board cell). An all-zero cell is
  // BLANK; an all-ones cell (of whatever cell width) is IMPASSABLE.
  localparam logic [4:0] RANK_BLANK  = 5'd0;
  localparam logic [4:0] RANK_F      = 5'd1;
  localparam logic [4:0] RANK_B      = 5'd2;
  localparam logic [4:0] RANK_S      = 5'd3;
  localparam logic [4:0] RANK_R2     = 5'd4;
  localparam logic [4:0] RANK_R3     = 5'd5;
  localparam logic [4:0] RANK_R9     = 5'd6;
  localparam logic [4:0] RANK_R10    = 5'd7;
  localparam logic [4:0] RANK_IMPASS = 5'h1F;

  typedef enum logic [1:0] {
    CMD_CAPTURE = 2'b00,
    CMD_DIE     = 2'b01,
    CMD_TRADE   = 2'b10
  } cmd_e;

  typedef enum logic [2:0] {
    ST_SETUP    = 3'd0,
    ST_SEL_SRC  = 3'd1,
    ST_RD_SRC   = 3'd2,
    ST_SEL_DST  = 3'd3,
    ST_RD_DST   = 3'd4,
    ST_ISSUE    = 3'd5,
    ST_WAIT_ACK = 3'd6,
    ST_OVER     = 3'd7
  } state_e;

endpackage

// File: rtl/stratego_turn_fsm_combat_resolve.sv
// Combinational combat outcome: attacker rank against the defender cell.
module combat_resolve
  import stratego_turn_fsm_pkg::*;
#(
  parameter int TW = 1,
  localparam int CELL_W = TW + 5
) (
  input  logic [4:0]        att_rank,
  input  logic [CELL_W-1:0] def_cell,
  output logic [1:0]        cmd,
  output logic              flag_hit
);

  logic [4:0] def_rank;
  assign def_rank = def_cell[4:0];

  // Ordered rule chain; earlier rules take priority over later ones.
  always_comb begin
    cmd      = CMD_DIE;
    flag_hit = 1'b0;
    if (def_cell == '0) begin
      cmd = CMD_CAPTURE;
    end else if (att_rank == def_rank) begin
      cmd = CMD_TRADE;
    end else if (def_rank == RANK_B) begin
      cmd = (att_rank == RANK_R3) ? CMD_CAPTURE : CMD_DIE;
    end else if (def_rank == RANK_F) begin
      cmd      = CMD_CAPTURE;
      flag_hit = 1'b1;
    end else if ((att_rank == RANK_S) && (def_rank == RANK_R10)) begin
      cmd = CMD_CAPTURE;
    end else if (att_rank > def_rank) begin
      cmd = CMD_CAPTURE;
    end
  end

endmodule

// File: rtl/stratego_turn_fsm.sv
// Turn sequencer: source/destination selection, board reads, combat command
// issue and handshake, per-turn timeout and game-over detection.
//
// state     | meaning
// ----------+--------------------------------------------------
// SETUP     | waiting for piece placement to finish
// SEL_SRC   | waiting for the player to confirm a source cell
// RD_SRC    | source cell read outstanding
// SEL_DST   | waiting for an adjacent destination (or cancel)
// RD_DST    | destination cell read outstanding
// ISSUE     | first cycle of the move command
// WAIT_ACK  | holding the move command until the updater accepts
// OVER      | flag captured; terminal until reset
module stratego_turn_fsm
  import stratego_turn_fsm_pkg::*;
#(
  parameter int COLS         = 8,
  parameter int ROWS         = 8,
  parameter int N_PLAYERS    = 2,
  parameter int TURN_TIMEOUT = 0,
  localparam int TW     = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1,
  localparam int XW     = $clog2(COLS),
  localparam int YW     = $clog2(ROWS),
  localparam int CELL_W = TW + 5,
  localparam int AW     = $clog2(COLS * ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              setup_done,
  input  logic              go,
  input  logic              back,
  input  logic [XW-1:0]     sel_x,
  input  logic [YW-1:0]     sel_y,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic              rd_valid,
  input  logic [CELL_W-1:0] rd_data,
  output logic              cmd_valid,
  output logic [1:0]        cmd,
  output logic [XW-1:0]     src_x,
  output logic [YW-1:0]     src_y,
  output logic [XW-1:0]     dst_x,
  output logic [YW-1:0]     dst_y,
  input  logic              cmd_ack,
  output logic [TW-1:0]     turn_player,
  output logic [2:0]        phase,
  output logic              illegal,
  output logic              timeout,
  output logic              game_over
);

  localparam int CW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LOAD = (TURN_TIMEOUT > 0) ? CW'(TURN_TIMEOUT - 1) : '0;
  localparam logic TO_EN = (TURN_TIMEOUT > 0);
  localparam logic [TW-1:0] LAST_PLAYER = TW'(N_PLAYERS - 1);

  state_e state, state_nxt;
  logic [CW-1:0] to_cnt;
  logic [4:0]    att_rank;
  logic          flag_hit;
  logic [1:0]    res_cmd;
  logic          res_flag;
  logic [AW-1:0] sel_addr;

  logic [TW-1:0] rd_team;
  logic [4:0]    rd_rank;
  logic rd_blank, rd_impass;
  logic counting, tmo_hit, cnt_load, turn_adv;
  logic src_go, src_ok, src_acc, src_rej;
  logic x_step, y_step, adj;
  logic dst_back, dst_go, dst_far, dst_bad, dst_acc, dst_rej, ack_done;

  assign rd_team   = rd_data[CELL_W-1 -: TW];
  assign rd_rank   = rd_data[4:0];
  assign rd_blank  = (rd_data == '0);
  assign rd_impass = (rd_data == '1);
  assign sel_addr  = AW'(sel_y) * AW'(COLS) + AW'(sel_x);

  // Timeout beats every other event in the counted states.
  assign counting = state inside {ST_SEL_SRC, ST_RD_SRC, ST_SEL_DST, ST_RD_DST};
  assign tmo_hit  = TO_EN && counting && (to_cnt == '0);

  assign src_go  = (state == ST_SEL_SRC) && go && !tmo_hit;
  assign src_ok  = !rd_blank && !rd_impass && (rd_team == turn_player) &&
                   (rd_rank != RANK_F) && (rd_rank != RANK_B);
  assign src_acc = (state == ST_RD_SRC) && rd_valid && !tmo_hit && src_ok;
  assign src_rej = (state == ST_RD_SRC) && rd_valid && !tmo_hit && !src_ok;

  // Widened by one bit so that a step across the coordinate wrap is not adjacent.
  assign x_step = ({1'b0, sel_x} == {1'b0, src_x} + (XW+1)'(1)) ||
                  ({1'b0, src_x} == {1'b0, sel_x} + (XW+1)'(1));
  assign y_step = ({1'b0, sel_y} == {1'b0, src_y} + (YW+1)'(1)) ||
                  ({1'b0, src_y} == {1'b0, sel_y} + (YW+1)'(1));
  assign adj    = (x_step && (sel_y == src_y)) || (y_step && (sel_x == src_x));

  assign dst_back = (state == ST_SEL_DST) && back && !tmo_hit;
  assign dst_go   = (state == ST_SEL_DST) && go && !back && !tmo_hit && adj;
  assign dst_far  = (state == ST_SEL_DST) && go && !back && !tmo_hit && !adj;
  assign dst_bad  = rd_impass || (!rd_blank && (rd_team == turn_player));
  assign dst_acc  = (state == ST_RD_DST) && rd_valid && !tmo_hit && !dst_bad;
  assign dst_rej  = (state == ST_RD_DST) && rd_valid && !tmo_hit && dst_bad;
  assign ack_done = (state == ST_WAIT_ACK) && cmd_ack;

  assign turn_adv = tmo_hit || (ack_done && !flag_hit);
  assign cnt_load = (state_nxt == ST_SEL_SRC) && ((state != ST_SEL_SRC) || tmo_hit);

  combat_resolve #(.TW(TW)) u_combat (
    .att_rank (att_rank),
    .def_cell (rd_data),
    .cmd      (res_cmd),
    .flag_hit (res_flag)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_SETUP;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SETUP:    if (setup_done) state_nxt = ST_SEL_SRC;
      ST_SEL_SRC:  if (src_go) state_nxt = ST_RD_SRC;
      ST_RD_SRC: begin
        if (src_acc)      state_nxt = ST_SEL_DST;
        else if (src_rej) state_nxt = ST_SEL_SRC;
      end
      ST_SEL_DST: begin
        if (dst_back)    state_nxt = ST_SEL_SRC;
        else if (dst_go) state_nxt = ST_RD_DST;
      end
      ST_RD_DST: begin
        if (dst_acc)      state_nxt = ST_ISSUE;
        else if (dst_rej) state_nxt = ST_SEL_DST;
      end
      ST_ISSUE:    state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: if (ack_done) state_nxt = flag_hit ? ST_OVER : ST_SEL_SRC;
      ST_OVER:     state_nxt = ST_OVER;
      default:     state_nxt = ST_SETUP;
    endcase
    if (tmo_hit) state_nxt = ST_SEL_SRC;
  end

  // State-decoded outputs.
  always_comb begin
    phase     = state;
    cmd_valid = (state == ST_ISSUE) || (state == ST_WAIT_ACK);
    game_over = (state == ST_OVER);
  end

  // Selection, read request, command and turn registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      illegal     <= 1'b0;
      timeout     <= 1'b0;
      src_x       <= '0;
      src_y       <= '0;
      dst_x       <= '0;
      dst_y       <= '0;
      att_rank    <= '0;
      cmd         <= CMD_CAPTURE;
      flag_hit    <= 1'b0;
      turn_player <= '0;
    end else begin
      rd_en   <= src_go || dst_go;
      illegal <= src_rej || dst_far || dst_rej;
      timeout <= tmo_hit;
      if (src_go) begin
        src_x   <= sel_x;
        src_y   <= sel_y;
        rd_addr <= sel_addr;
      end
      if (dst_go) begin
        dst_x   <= sel_x;
        dst_y   <= sel_y;
        rd_addr <= sel_addr;
      end
      if (src_acc) att_rank <= rd_rank;
      if (dst_acc) begin
        cmd      <= res_cmd;
        flag_hit <= res_flag;
      end
      if (turn_adv) turn_player <= (turn_player == LAST_PLAYER) ? '0 : turn_player + 1'b1;
    end
  end

  // Per-turn down-counter; reloaded whenever SEL_SRC is (re)entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          to_cnt <= '0;
    else if (cnt_load)                  to_cnt <= TO_LOAD;
    else if (counting && to_cnt != '0)  to_cnt <= to_cnt - 1'b1;
  end

endmodule

// File: tb/tb_stratego_turn_fsm.sv
module tb_stratego_turn_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, setup_done, go, back, rd_valid, cmd_ack;
  logic [2:0] sel_x, sel_y;
  logic [5:0] rd_data;
  logic       rd_en, cmd_valid, illegal, timeout, game_over;
  logic [5:0] rd_addr;
  logic [1:0] cmd;
  logic [2:0] src_x, src_y, dst_x, dst_y, phase;
  logic [0:0] turn_player;

  logic       b_go, b_back, b_rd_valid, b_cmd_ack;
  logic [2:0] b_sel_x, b_sel_y;
  logic [6:0] b_rd_data;
  logic       b_rd_en, b_cmd_valid, b_illegal, b_timeout, b_game_over;
  logic [5:0] b_rd_addr;
  logic [1:0] b_cmd;
  logic [2:0] b_src_x, b_src_y, b_dst_x, b_dst_y, b_phase;
  logic [1:0] b_turn_player;

  stratego_turn_fsm dut (
    .clk(clk), .reset(reset), .setup_done(setup_done), .go(go), .back(back),
    .sel_x(sel_x), .sel_y(sel_y), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .cmd_valid(cmd_valid), .cmd(cmd),
    .src_x(src_x), .src_y(src_y), .dst_x(dst_x), .dst_y(dst_y),
    .cmd_ack(cmd_ack), .turn_player(turn_player), .phase(phase),
    .illegal(illegal), .timeout(timeout), .game_over(game_over)
  );

  stratego_turn_fsm #(.N_PLAYERS(3), .TURN_TIMEOUT(20)) dut_b (
    .clk(clk), .reset(reset), .setup_done(setup_done), .go(b_go), .back(b_back),
    .sel_x(b_sel_x), .sel_y(b_sel_y), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .cmd_valid(b_cmd_valid), .cmd(b_cmd),
    .src_x(b_src_x), .src_y(b_src_y), .dst_x(b_dst_x), .dst_y(b_dst_y),
    .cmd_ack(b_cmd_ack), .turn_player(b_turn_player), .phase(b_phase),
    .illegal(b_illegal), .timeout(b_timeout), .game_over(b_game_over)
  );

  int n_vec = 0;
  int n_mis = 0;
  logic [5:0] board [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sel_go(input int x, input int y);
    sel_x = 3'(x);
    sel_y = 3'(y);
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic read_resp(input string tag, input int x, input int y, input int lat);
    check({tag, " rd_en"}, rd_en, 1);
    check({tag, " rd_addr"}, rd_addr, y * 8 + x);
    repeat (lat - 1) tick();
    rd_valid = 1'b1;
    rd_data  = board[y * 8 + x];
    tick();
    rd_valid = 1'b0;
    check({tag, " rd_en drop"}, rd_en, 0);
  endtask

  task automatic pick_src(input string tag, input int x, input int y, input int lat, input bit ok);
    sel_go(x, y);
    check({tag, " phase rd_src"}, phase, 2);
    read_resp(tag, x, y, lat);
    if (ok) begin
      check({tag, " phase sel_dst"}, phase, 3);
      check({tag, " no illegal"}, illegal, 0);
    end else begin
      check({tag, " phase back to sel_src"}, phase, 1);
      check({tag, " illegal"}, illegal, 1);
      tick();
      check({tag, " illegal one cycle"}, illegal, 0);
    end
  endtask

  task automatic finish_move(input string tag, input int sx, input int sy, input int dx, input int dy,
                             input int lat, input logic [1:0] exp_cmd, input logic [2:0] exp_phase,
                             input logic exp_turn);
    sel_go(dx, dy);
    check({tag, " phase rd_dst"}, phase, 4);
    read_resp(tag, dx, dy, lat);
    check({tag, " phase issue"}, phase, 5);
    check({tag, " cmd_valid"}, cmd_valid, 1);
    check({tag, " cmd"}, cmd, exp_cmd);
    check({tag, " endpoints"}, {src_x, src_y, dst_x, dst_y}, {3'(sx), 3'(sy), 3'(dx), 3'(dy)});
    tick();
    check({tag, " phase wait_ack"}, phase, 6);
    check({tag, " cmd held"}, {cmd_valid, cmd}, {1'b1, exp_cmd});
    tick();
    check({tag, " still waiting"}, phase, 6);
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    check({tag, " cmd_valid drop"}, cmd_valid, 0);
    check({tag, " phase after ack"}, phase, exp_phase);
    check({tag, " turn after ack"}, turn_player, exp_turn);
    check({tag, " game_over"}, game_over, (exp_phase == 3'd7));
  endtask

  task automatic p1_move(input string tag);
    pick_src(tag, 6, 6, 1, 1'b1);
    finish_move(tag, 6, 6, 6, 7, 1, 2'b00, 3'd1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; setup_done = 1'b0; go = 1'b0; back = 1'b0; rd_valid = 1'b0;
    cmd_ack = 1'b0; sel_x = '0; sel_y = '0; rd_data = '0;
    b_go = 1'b0; b_back = 1'b0; b_rd_valid = 1'b0; b_cmd_ack = 1'b0;
    b_sel_x = '0; b_sel_y = '0; b_rd_data = '0;

    for (int i = 0; i < 64; i++) board[i] = 6'h00;
    board[18] = {1'b0, 5'd6};   // (2,2) P0 R9
    board[9]  = {1'b0, 5'd5};   // (1,1) P0 R3
    board[36] = {1'b0, 5'd3};   // (4,4) P0 S
    board[56] = {1'b0, 5'd1};   // (0,7) P0 F
    board[8]  = {1'b0, 5'd4};   // (0,1) P0 R2
    board[17] = {1'b1, 5'd2};   // (1,2) P1 B
    board[19] = {1'b1, 5'd2};   // (3,2) P1 B
    board[10] = {1'b1, 5'd6};   // (2,1) P1 R9
    board[44] = {1'b1, 5'd7};   // (4,5) P1 R10
    board[37] = {1'b1, 5'd1};   // (5,4) P1 F
    board[54] = {1'b1, 5'd4};   // (6,6) P1 R2
    board[7]  = 6'h3F;          // (7,0) impassable
    board[1]  = 6'h3F;          // (1,0) impassable

    tick(); tick();
    check("reset phase", phase, 0);
    check("reset outputs", {turn_player, cmd_valid, cmd, rd_en, rd_addr, illegal, timeout, game_over}, 0);
    check("reset b", {b_phase, b_turn_player, b_timeout}, 0);
    reset = 1'b0;
    tick();
    check("setup hold", phase, 0);
    setup_done = 1'b1;
    tick();
    check("enter sel_src", phase, 1);
    check("enter sel_src b", b_phase, 1);
    check("turn 0 at start", turn_player, 0);

    // Timeout on the 3-player / 20-cycle instance.
    repeat (19) tick();
    check("b no timeout yet", b_timeout, 0);
    tick();
    check("b timeout 1", b_timeout, 1);
    check("b turn 1", b_turn_player, 1);
    check("b phase after timeout", b_phase, 1);
    tick();
    check("b timeout pulse", b_timeout, 0);
    repeat (18) tick();
    tick();
    check("b timeout 2", {b_timeout, b_turn_player}, {1'b1, 2'd2});
    repeat (19) tick();
    tick();
    check("b timeout wrap", {b_timeout, b_turn_player}, {1'b1, 2'd0});
    check("b idle outputs", {b_rd_en, b_rd_addr, b_cmd_valid, b_cmd, b_src_x, b_src_y,
                             b_dst_x, b_dst_y, b_illegal, b_game_over}, 0);
    check("a no timeout", {timeout, phase}, {1'b0, 3'd1});

    // Basic move into a blank cell, then P1 replies.
    pick_src("m1", 2, 2, 1, 1'b1);
    finish_move("m1", 2, 2, 2, 3, 2, 2'b00, 3'd1, 1'b1);
    p1_move("p1a");

    // Rejected sources.
    pick_src("src own F", 0, 7, 1, 1'b0);
    pick_src("src opponent", 4, 5, 1, 1'b0);
    pick_src("src blank", 2, 3, 3, 1'b0);
    pick_src("src impassable", 7, 0, 1, 1'b0);

    // Slow source read with go pulses that must be ignored.
    sel_go(2, 2);
    check("slow rd_addr", rd_addr, 18);
    for (int i = 0; i < 4; i++) begin
      sel_x = 3'd0; sel_y = 3'd0;
      go = (i % 2 == 0);
      tick();
      go = 1'b0;
      check("slow phase", phase, 2);
      check("slow no rd_en", rd_en, 0);
      check("slow src held", {src_x, src_y}, {3'd2, 3'd2});
    end
    rd_valid = 1'b1; rd_data = board[18];
    tick();
    rd_valid = 1'b0;
    check("slow accept", phase, 3);

    sel_go(2, 4);
    check("dist2 phase", phase, 3);
    check("dist2 illegal", {illegal, rd_en}, {1'b1, 1'b0});
    tick();
    check("dist2 pulse", illegal, 0);
    sel_go(3, 3);
    check("diag illegal", {illegal, phase}, {1'b1, 3'd3});
    tick();
    back = 1'b1;
    tick();
    back = 1'b0;
    check("back phase", phase, 1);

    pick_src("again", 2, 2, 1, 1'b1);
    back = 1'b1; sel_x = 3'd2; sel_y = 3'd3; go = 1'b1;
    tick();
    back = 1'b0; go = 1'b0;
    check("back beats go", {phase, rd_en, illegal}, {3'd1, 1'b0, 1'b0});

    // Rejected destinations, then R3 takes a bomb.
    pick_src("r3", 1, 1, 1, 1'b1);
    sel_go(1, 0);
    read_resp("dst imp", 1, 0, 1);
    check("dst imp", {phase, illegal}, {3'd3, 1'b1});
    tick();
    sel_go(0, 1);
    read_resp("dst own", 0, 1, 2);
    check("dst own", {phase, illegal}, {3'd3, 1'b1});
    tick();
    finish_move("r3xB", 1, 1, 1, 2, 1, 2'b00, 3'd1, 1'b1);
    p1_move("p1b");

    pick_src("r9", 2, 2, 1, 1'b1);
    finish_move("r9xB", 2, 2, 3, 2, 1, 2'b01, 3'd1, 1'b1);
    p1_move("p1c");

    pick_src("spy", 4, 4, 1, 1'b1);
    finish_move("SxR10", 4, 4, 4, 5, 1, 2'b00, 3'd1, 1'b1);
    p1_move("p1d");

    pick_src("r9b", 2, 2, 1, 1'b1);
    finish_move("r9xR9", 2, 2, 2, 1, 4, 2'b10, 3'd1, 1'b1);
    p1_move("p1e");

    pick_src("flag", 4, 4, 1, 1'b1);
    finish_move("SxF", 4, 4, 5, 4, 1, 2'b00, 3'd7, 1'b0);
    sel_go(2, 2);
    check("over ignores go", {phase, rd_en, game_over}, {3'd7, 1'b0, 1'b1});

    // Asynchronous reset while a command waits for acknowledge.
    reset = 1'b1;
    #1;
    check("reset from over", {phase, game_over}, 0);
    tick();
    reset = 1'b0;
    tick();
    check("restart", phase, 1);
    pick_src("r m1", 2, 2, 1, 1'b1);
    finish_move("r m1", 2, 2, 2, 3, 1, 2'b00, 3'd1, 1'b1);
    pick_src("r p1", 6, 6, 1, 1'b1);
    sel_go(6, 7);
    read_resp("r p1", 6, 7, 1);
    tick();
    check("pre-reset waiting", {phase, cmd_valid, turn_player}, {3'd6, 1'b1, 1'b1});
    #2;
    reset = 1'b1;
    #1;
    check("async reset phase", phase, 0);
    check("async reset turn", turn_player, 0);
    check("async reset cmd_valid", cmd_valid, 0);
    check("async reset rest", {cmd, src_x, src_y, dst_x, dst_y, rd_en, rd_addr,
                               illegal, timeout, game_over}, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
